// File: rtl/vkl_sum_pkg.sv
// vkl_sum_pkg: shared types and constants for the vkl_sum_engine slice.
// Holds the operating-mode and FSM-state enums plus the minimum accumulator width helper.
package vkl_sum_pkg;

    typedef enum logic [1:0] {
        MODE_ADD  = 2'b00,
        MODE_SUB  = 2'b01,
        MODE_ACC  = 2'b10,
        MODE_RSVD = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_DRAIN = 2'b10
    } state_e;

    // One bit of headroom so a full a+b sum always fits the result.
    localparam int ACC_W_HEADROOM = 1;

    function automatic int min_acc_w(input int width);
        return width + ACC_W_HEADROOM;
    endfunction

endpackage

// File: rtl/vkl_sum_alu.sv
// vkl_sum_alu: combinational datapath for vkl_sum_engine (ADD / SUB / ACC step).
// Ports: a, b (operands), acc (running sum), mode -> res (next result), ovf (ACC carry).
// Macro VKL_SUM_SAT_EN: when defined, an ACC carry saturates res to all-ones.
module vkl_sum_alu
    import vkl_sum_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int ACC_W = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [ACC_W-1:0] acc,
    input  logic [1:0]       mode,
    output logic [ACC_W-1:0] res,
    output logic             ovf
);

    logic [ACC_W-1:0] a_x;
    logic [ACC_W-1:0] b_x;
    logic [ACC_W:0]   sum;

    assign a_x = {{(ACC_W-WIDTH){1'b0}}, a};
    assign b_x = {{(ACC_W-WIDTH){1'b0}}, b};
    // One extra bit catches the carry out of the accumulator.
    assign sum = {1'b0, acc} + {1'b0, a_x} + {1'b0, b_x};

    always_comb begin
        res = '0;
        ovf = 1'b0;
        case (mode_e'(mode))
            MODE_SUB: res = a_x - b_x;
            MODE_ACC: begin
                ovf = sum[ACC_W];
`ifdef VKL_SUM_SAT_EN
                res = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
`else
                res = sum[ACC_W-1:0];
`endif
            end
            default:  res = a_x + b_x;
        endcase
    end

endmodule

// File: rtl/vkl_sum_engine.sv
// vkl_sum_engine: sequential adder / subtractor / burst accumulator with valid/ready I/O.
// Ports: clk, rst_n, ena; start/mode/len program a transaction; a, b with in_valid/in_ready
// feed pairs; out_data/out_ovf with out_valid/out_ready return results; busy = not idle.
// Macro VKL_SUM_SAT_EN: ACC overflow saturates instead of wrapping.
module vkl_sum_engine
    import vkl_sum_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LEN_W = 4,
    parameter int ACC_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             out_ovf,
    output logic             busy
);

    if (ACC_W < min_acc_w(WIDTH)) begin : g_bad_acc_w
        $error("vkl_sum_engine: ACC_W must be at least WIDTH+1");
    end

    state_e           state_q, state_d;
    mode_e            mode_q, mode_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             sticky_q, sticky_d;
    logic             out_valid_q, out_valid_d;
    logic [ACC_W-1:0] out_data_q, out_data_d;
    logic             out_ovf_q, out_ovf_d;

    logic [ACC_W-1:0] alu_res;
    logic             alu_ovf;
    logic             accept;
    logic             out_fire;
    logic             last;

    vkl_sum_alu #(
        .WIDTH (WIDTH),
        .ACC_W (ACC_W)
    ) u_alu (
        .a    (a),
        .b    (b),
        .acc  (acc_q),
        .mode (mode_q),
        .res  (alu_res),
        .ovf  (alu_ovf)
    );

    // Single output register: a new pair may enter while the held result leaves.
    assign in_ready = ena && (state_q == ST_RUN) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign out_fire = ena && out_valid_q && out_ready;
    assign last     = (cnt_q == '0);

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        sticky_d    = sticky_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ovf_d   = out_ovf_q;
        if (ena) begin
            if (out_fire) begin
                out_valid_d = 1'b0;
            end
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        mode_d   = mode_e'(mode);
                        cnt_d    = len;
                        acc_d    = '0;
                        sticky_d = 1'b0;
                        state_d  = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        if (last) begin
                            state_d = ST_DRAIN;
                        end else begin
                            cnt_d = cnt_q - LEN_W'(1);
                        end
                        if (mode_q == MODE_ACC) begin
                            acc_d    = alu_res;
                            sticky_d = sticky_q | alu_ovf;
                            if (last) begin
                                out_valid_d = 1'b1;
                                out_data_d  = alu_res;
                                out_ovf_d   = sticky_q | alu_ovf;
                            end
                        end else begin
                            out_valid_d = 1'b1;
                            out_data_d  = alu_res;
                            out_ovf_d   = 1'b0;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!out_valid_q || out_fire) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            mode_q      <= MODE_ADD;
            cnt_q       <= '0;
            acc_q       <= '0;
            sticky_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            sticky_q    <= sticky_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;
    assign busy      = (state_q != ST_IDLE);

endmodule
